// File: rtl/axis_rr_arb.sv
// Packet-aware round-robin arbiter merging N AXI-stream sources onto one registered sink port.
// A grant stays with one source until that source's tlast beat is accepted.
module axis_rr_arb #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 4,
  parameter int unsigned IW    = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] s_axis_tdata,
  input  logic [N-1:0]       s_axis_tvalid,
  output logic [N-1:0]       s_axis_tready,
  input  logic [N-1:0]       s_axis_tlast,
  output logic [WIDTH-1:0]   m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               m_axis_tlast,
  output logic [IW-1:0]      m_axis_tid
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             last_q, last_d;
  logic             valid_q, valid_d;
  logic [IW-1:0]    tid_q, tid_d;

  logic [WIDTH-1:0] src_data [N];
  logic [IW-1:0]    arb_idx;
  logic [IW-1:0]    cand;
  logic             arb_found;
  logic             grant_ready;
  logic             accept;

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign src_data[i] = s_axis_tdata[i*WIDTH +: WIDTH];
  end

  // First requester after the last-granted source, wrapping modulo N.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = ptr_q;
    cand      = ptr_q;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = IW'((32'(ptr_q) + k) % N);
      if (!arb_found && s_axis_tvalid[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    data_d        = data_q;
    last_d        = last_q;
    valid_d       = valid_q;
    tid_d         = tid_q;
    s_axis_tready = '0;
    grant_ready   = ~valid_q | m_axis_tready;
    accept        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (arb_found) begin
          state_d = StBusy;
          ptr_d   = arb_idx;
        end
      end
      StBusy: begin
        s_axis_tready[ptr_q] = grant_ready;
        accept = s_axis_tvalid[ptr_q] & grant_ready;
        if (accept && s_axis_tlast[ptr_q]) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A new beat takes priority over a drain so a pending beat is never dropped.
    if (accept) begin
      valid_d = 1'b1;
      data_d  = src_data[ptr_q];
      last_d  = s_axis_tlast[ptr_q];
      tid_d   = ptr_q;
    end else if (m_axis_tready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= IW'(N - 1);
      data_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      tid_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      tid_q   <= tid_d;
    end
  end

  assign m_axis_tdata  = data_q;
  assign m_axis_tlast  = last_q;
  assign m_axis_tvalid = valid_q;
  assign m_axis_tid    = tid_q;

endmodule

// File: tb/tb_axis_rr_arb.sv
// Bench for axis_rr_arb: cycle vector table, hand sequences, and randomized packet traffic
// checked against a packet-level round-robin model.
module tb_axis_rr_arb;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned N     = 4;
  localparam int unsigned IW    = 2;
  localparam int unsigned BW    = IW + 1 + WIDTH;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [N*WIDTH-1:0] s_tdata = '0;
  logic [N-1:0]       s_tvalid = '0;
  logic [N-1:0]       s_tready;
  logic [N-1:0]       s_tlast = '0;
  logic [WIDTH-1:0]   m_tdata;
  logic               m_tvalid;
  logic               m_ready = 1'b1;
  logic               m_tlast;
  logic [IW-1:0]      m_tid;

  always #5 clk = ~clk;

  axis_rr_arb #(
    .WIDTH(WIDTH),
    .N    (N)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_axis_tdata (s_tdata),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .s_axis_tlast (s_tlast),
    .m_axis_tdata (m_tdata),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_ready),
    .m_axis_tlast (m_tlast),
    .m_axis_tid   (m_tid)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] src_word(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  typedef struct {
    logic          rst_n;
    logic [N-1:0]  valid;
    logic          mready;
    logic [N-1:0]  sready;
    logic          mvalid;
    logic [IW-1:0] tid;
    logic          mlast;
  } vec_t;

  vec_t vecs[18];

  // Packet-driver state shared by the traffic tests.
  logic [WIDTH:0] src_q[N][$];
  logic [WIDTH:0] gen_q[N][$];
  logic [BW-1:0]  out_q[$];
  int             out_cyc[$];
  bit             mid[N];
  int             cyc = 0;
  int             ready_mode = 0;
  int             drop_pct = 0;
  int             stall_lo = 0;
  int             stall_hi = 0;
  bit             prev_stall = 1'b0;
  logic [BW-1:0]  prev_beat = '0;

  task automatic step();
    bit            drop;
    logic [BW-1:0] cur;
    logic [WIDTH:0] b;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < N; i++) begin
      drop = mid[i] && ($urandom_range(99) < drop_pct);
      if (src_q[i].size() > 0 && !drop) begin
        b = src_q[i][0];
        s_tvalid[i] = 1'b1;
        s_tdata[i*WIDTH +: WIDTH] = b[WIDTH-1:0];
        s_tlast[i] = b[WIDTH];
      end else begin
        s_tvalid[i] = 1'b0;
        s_tlast[i] = 1'b0;
      end
    end
    case (ready_mode)
      1:       m_ready = ($urandom_range(3) != 0);
      2:       m_ready = !(cyc >= stall_lo && cyc < stall_hi);
      default: m_ready = 1'b1;
    endcase
    #4;
    cur = {m_tid, m_tlast, m_tdata};
    check("ready_onehot0", 64'($onehot0(s_tready)), 64'd1);
    if (m_tvalid && !m_ready) check("ready_blocked", s_tready, 0);
    if (prev_stall) check("hold_stable", {m_tvalid, cur}, {1'b1, prev_beat});
    prev_stall = m_tvalid && !m_ready;
    prev_beat = cur;
    for (int i = 0; i < N; i++) begin
      if (s_tvalid[i] && s_tready[i]) begin
        b = src_q[i].pop_front();
        mid[i] = !b[WIDTH];
      end
    end
    if (m_tvalid && m_ready) begin
      out_q.push_back(cur);
      out_cyc.push_back(cyc);
    end
  endtask

  task automatic reset_dut();
    prev_stall = 1'b0;
    ready_mode = 0;
    drop_pct = 0;
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      gen_q[i].delete();
      mid[i] = 1'b0;
    end
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    prev_stall = 1'b0;
    out_q.delete();
    out_cyc.delete();
  endtask

  task automatic add_packet(input int src, input int len);
    logic [WIDTH:0] b;
    for (int k = 0; k < len; k++) begin
      b[WIDTH-1:0] = $urandom;
      b[WIDTH] = (k == len - 1);
      src_q[src].push_back(b);
      gen_q[src].push_back(b);
    end
  endtask

  // Expected stream: whole packets, sources visited in rotation starting after N-1,
  // skipping sources with nothing left to send.
  task automatic run_compare(input string name, input int budget);
    logic [BW-1:0]  exp_q[$];
    logic [WIDTH:0] b;
    int ptr = N - 1;
    int pick;
    int n = 0;
    bit done = 1'b0;
    while (!done) begin
      pick = -1;
      for (int k = 1; k <= N; k++) begin
        if (pick < 0 && gen_q[(ptr + k) % N].size() > 0) pick = (ptr + k) % N;
      end
      if (pick < 0) begin
        done = 1'b1;
      end else begin
        ptr = pick;
        do begin
          b = gen_q[pick].pop_front();
          exp_q.push_back({IW'(pick), b});
        end while (!b[WIDTH]);
      end
    end
    while (out_q.size() < exp_q.size() && n < budget) begin
      step();
      n++;
    end
    repeat (4) step();
    check({name, "_beat_count"}, out_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k < out_q.size()) check($sformatf("%s_beat%0d", name, k), out_q[k], exp_q[k]);
    end
  endtask

  task automatic drive(input logic rst, input logic [N-1:0] valid, input logic mready);
    @(negedge clk);
    rst_n = rst;
    s_tvalid = valid;
    s_tlast = '0;
    m_ready = mready;
    #4;
  endtask

  initial begin
    int t2_tid[10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    logic [BW-1:0] beat;

    // Single-beat packets from sources 0 and 3, sink stall, and a grant held while src0 idles.
    vecs[0]  = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[1]  = '{1'b1, 4'b1001, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[2]  = '{1'b1, 4'b1001, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b0};
    vecs[3]  = '{1'b1, 4'b1001, 1'b1, 4'b0000, 1'b1, 2'd0, 1'b1};
    vecs[4]  = '{1'b1, 4'b1001, 1'b1, 4'b1000, 1'b0, 2'd0, 1'b1};
    vecs[5]  = '{1'b1, 4'b1001, 1'b1, 4'b0000, 1'b1, 2'd3, 1'b1};
    vecs[6]  = '{1'b1, 4'b1001, 1'b1, 4'b0001, 1'b0, 2'd3, 1'b1};
    vecs[7]  = '{1'b1, 4'b1001, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b1};
    vecs[8]  = '{1'b1, 4'b1001, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b1};
    vecs[9]  = '{1'b1, 4'b1001, 1'b1, 4'b1000, 1'b1, 2'd0, 1'b1};
    vecs[10] = '{1'b1, 4'b1001, 1'b1, 4'b0000, 1'b1, 2'd3, 1'b1};
    vecs[11] = '{1'b1, 4'b0000, 1'b1, 4'b0001, 1'b0, 2'd3, 1'b1};
    vecs[12] = '{1'b1, 4'b1000, 1'b1, 4'b0001, 1'b0, 2'd3, 1'b1};
    vecs[13] = '{1'b1, 4'b1001, 1'b1, 4'b0001, 1'b0, 2'd3, 1'b1};
    vecs[14] = '{1'b1, 4'b1000, 1'b1, 4'b0000, 1'b1, 2'd0, 1'b1};
    vecs[15] = '{1'b1, 4'b1000, 1'b1, 4'b1000, 1'b0, 2'd0, 1'b1};
    vecs[16] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd3, 1'b1};
    vecs[17] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, 1'b1};

    s_tvalid = '1;
    s_tlast = '1;
    for (int i = 0; i < N; i++) s_tdata[i*WIDTH +: WIDTH] = src_word(i);
    repeat (2) @(posedge clk);

    for (int r = 0; r < 18; r++) begin
      @(negedge clk);
      rst_n = vecs[r].rst_n;
      s_tvalid = vecs[r].valid;
      s_tlast = vecs[r].valid;
      m_ready = vecs[r].mready;
      #4;
      check($sformatf("vec%0d_s_tready", r), s_tready, vecs[r].sready);
      check($sformatf("vec%0d_m_tvalid", r), m_tvalid, vecs[r].mvalid);
      check($sformatf("vec%0d_m_tid", r), m_tid, vecs[r].tid);
      check($sformatf("vec%0d_m_tlast", r), m_tlast, vecs[r].mlast);
      check($sformatf("vec%0d_m_tdata", r), m_tdata,
            vecs[r].mlast ? src_word(int'(vecs[r].tid)) : '0);
    end

    // Reset on beat 2 of src1's packet; the pointer must restart so src1 beats src2 again.
    drive(1'b1, 4'b0110, 1'b1);
    drive(1'b1, 4'b0110, 1'b1);
    check("t6_grant_src1", s_tready, 4'b0010);
    drive(1'b1, 4'b0110, 1'b1);
    check("t6_beat1_valid", m_tvalid, 1);
    check("t6_beat1_tid", m_tid, 1);
    drive(1'b0, 4'b0110, 1'b1);
    check("t6_beat2_valid", m_tvalid, 1);
    drive(1'b1, 4'b0110, 1'b1);
    check("t6_reset_valid", m_tvalid, 0);
    check("t6_reset_ready", s_tready, 0);
    drive(1'b1, 4'b0110, 1'b1);
    check("t6_regrant_src1", s_tready, 4'b0010);

    // Round robin over 2-beat packets with an always-ready sink.
    reset_dut();
    add_packet(0, 2);
    add_packet(0, 2);
    add_packet(1, 2);
    add_packet(2, 2);
    add_packet(3, 2);
    run_compare("t2_rr", 200);
    for (int k = 0; k < 10; k++) begin
      if (k < out_q.size()) begin
        beat = out_q[k];
        check($sformatf("t2_tid%0d", k), beat[BW-1 -: IW], t2_tid[k]);
      end
    end
    for (int k = 0; k < 9; k++) begin
      if (k + 1 < out_q.size()) begin
        check($sformatf("t2_gap%0d", k), out_cyc[k+1] - out_cyc[k], (k % 2 == 0) ? 1 : 2);
      end
    end

    // Five-cycle sink stall in the middle of a 3-beat packet.
    reset_dut();
    add_packet(1, 3);
    ready_mode = 2;
    stall_lo = cyc + 3;
    stall_hi = cyc + 8;
    run_compare("t3_bp", 100);

    // Random packets, random sink backpressure, random mid-packet source gaps.
    for (int round = 0; round < 6; round++) begin
      reset_dut();
      for (int i = 0; i < N; i++) begin
        int np;
        np = $urandom_range(4);
        for (int p = 0; p < np; p++) add_packet(i, $urandom_range(4, 1));
      end
      ready_mode = 1;
      drop_pct = 30;
      run_compare($sformatf("rand%0d", round), 3000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
